// File: rtl/ili_pkg.sv
// Shared ILI9341 command codes, coordinate type, draw FSM states and the
// per-pixel byte table used by spi_line_draw_n.
package ili_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int COORD_W_DEF = 9;
    typedef logic [COORD_W_DEF-1:0] coord_t;

    localparam logic [3:0] LAST_BYTE = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_STEP,
        ST_FIN
    } draw_state_t;

    // {dc, byte} for position idx of the 13-byte pixel sequence
    function automatic logic [8:0] pixel_byte(input logic [3:0] idx,
                                              input logic [15:0] x,
                                              input logic [15:0] y,
                                              input logic [15:0] c);
        logic [8:0] r;
        case (idx)
            4'd0:    r = {1'b0, CMD_CASET};
            4'd1:    r = {1'b1, x[15:8]};
            4'd2:    r = {1'b1, x[7:0]};
            4'd3:    r = {1'b1, x[15:8]};
            4'd4:    r = {1'b1, x[7:0]};
            4'd5:    r = {1'b0, CMD_PASET};
            4'd6:    r = {1'b1, y[15:8]};
            4'd7:    r = {1'b1, y[7:0]};
            4'd8:    r = {1'b1, y[15:8]};
            4'd9:    r = {1'b1, y[7:0]};
            4'd10:   r = {1'b0, CMD_RAMWR};
            4'd11:   r = {1'b1, c[15:8]};
            default: r = {1'b1, c[7:0]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spi_line_draw_n_if.sv
// Byte stream from the line rasteriser to the shared SPI byte shifter.
interface spi_line_draw_n_if;

    logic [7:0] o_byte;
    logic       o_dc;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_byte, output o_dc, output o_valid, input i_ready);
    modport slave  (input o_byte, input o_dc, input o_valid, output i_ready);

endinterface

// File: rtl/line_stepper.sv
// Bresenham state (x, y, err, direction) for one line; load latches endpoints,
// step advances one pixel. Also exposes the post-step position combinationally.
module line_stepper #(
    parameter int COORD_W = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic [COORD_W-1:0] o_x_next,
    output logic [COORD_W-1:0] o_y_next,
    output logic               o_at_end
);

    localparam int EW = COORD_W + 2;

    logic signed [EW-1:0] err, dx, dy;
    logic signed [EW-1:0] ld_dx, ld_dy, err_next;
    logic signed [EW:0]   e2;
    logic [COORD_W-1:0]   x_end, y_end;
    logic                 sx_neg, sy_neg;
    logic                 take_x, take_y;

    always_comb begin
        ld_dx = $signed({2'b00, i_x1}) - $signed({2'b00, i_x0});
        if (ld_dx[EW-1]) ld_dx = -ld_dx;
        ld_dy = $signed({2'b00, i_y1}) - $signed({2'b00, i_y0});
        if (!ld_dy[EW-1]) ld_dy = -ld_dy;

        // both axis decisions are taken from the same doubled error
        e2       = {err, 1'b0};
        take_x   = e2 >= $signed({dy[EW-1], dy});
        take_y   = e2 <= $signed({dx[EW-1], dx});
        err_next = err + (take_x ? dy : '0) + (take_y ? dx : '0);
        o_x_next = take_x ? (sx_neg ? o_x - 1'b1 : o_x + 1'b1) : o_x;
        o_y_next = take_y ? (sy_neg ? o_y - 1'b1 : o_y + 1'b1) : o_y;
    end

    assign o_at_end = (o_x == x_end) && (o_y == y_end);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_x    <= '0;
            o_y    <= '0;
            x_end  <= '0;
            y_end  <= '0;
            err    <= '0;
            dx     <= '0;
            dy     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (i_load) begin
            o_x    <= i_x0;
            o_y    <= i_y0;
            x_end  <= i_x1;
            y_end  <= i_y1;
            dx     <= ld_dx;
            dy     <= ld_dy;
            err    <= ld_dx + ld_dy;
            sx_neg <= i_x1 < i_x0;
            sy_neg <= i_y1 < i_y0;
        end else if (i_step) begin
            o_x <= o_x_next;
            o_y <= o_y_next;
            err <= err_next;
        end
    end

endmodule

// File: rtl/spi_line_draw_n.sv
// Bresenham line rasteriser emitting ILI9341 1x1-window pixel writes as a byte stream.
// Optional LINE_CLIP_EN: pixels outside H_RES x V_RES are stepped over without bytes.
module spi_line_draw_n
    import ili_pkg::*;
#(
    parameter int COORD_W = 9,
    parameter int COLOR_W = 16,
    parameter int H_RES   = 240,
    parameter int V_RES   = 320
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    input  logic [COLOR_W-1:0] i_color,
    spi_line_draw_n_if.master  tx,
    output logic               o_busy,
    output logic               o_done
);

`ifdef LINE_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    draw_state_t        state;
    logic [3:0]         idx;
    logic [COLOR_W-1:0] color_q;
    logic [COORD_W-1:0] x, y, x_next, y_next;
    logic               at_end, load, step;
    logic               vis_cur, vis_next, open_px;
    logic [8:0]         nxt;

    function automatic logic on_panel(input logic [COORD_W-1:0] px,
                                      input logic [COORD_W-1:0] py);
        return !CLIP || ((32'(px) < 32'(H_RES)) && (32'(py) < 32'(V_RES)));
    endfunction

    line_stepper #(.COORD_W(COORD_W)) u_stepper (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (load),
        .i_step   (step),
        .i_x0     (i_x0),
        .i_y0     (i_y0),
        .i_x1     (i_x1),
        .i_y1     (i_y1),
        .o_x      (x),
        .o_y      (y),
        .o_x_next (x_next),
        .o_y_next (y_next),
        .o_at_end (at_end)
    );

    // visibility of the step target is judged before the step lands, so a
    // visible pixel goes straight from STEP to EMIT
    always_comb begin
        load     = (state == ST_IDLE) && i_start;
        step     = (state == ST_STEP) && !at_end;
        vis_cur  = on_panel(x, y);
        vis_next = on_panel(x_next, y_next);
        open_px  = ((state == ST_LOAD) && vis_cur) || (step && vis_next);
        nxt      = pixel_byte(idx + 4'd1, 16'(x), 16'(y), 16'(color_q));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            color_q    <= '0;
            tx.o_valid <= 1'b0;
            tx.o_dc    <= 1'b0;
            tx.o_byte  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: if (i_start) begin
                    color_q <= i_color;
                    o_busy  <= 1'b1;
                    state   <= ST_LOAD;
                end
                ST_LOAD: state <= vis_cur ? ST_EMIT : ST_STEP;
                ST_EMIT: if (tx.o_valid && tx.i_ready) begin
                    if (idx == LAST_BYTE) begin
                        tx.o_valid <= 1'b0;
                        state      <= ST_STEP;
                    end else begin
                        idx       <= idx + 4'd1;
                        tx.o_dc   <= nxt[8];
                        tx.o_byte <= nxt[7:0];
                    end
                end
                ST_STEP: begin
                    if (at_end) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_FIN;
                    end else if (vis_next) begin
                        state <= ST_EMIT;
                    end
                end
                ST_FIN:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
            if (open_px) begin
                idx        <= '0;
                tx.o_valid <= 1'b1;
                tx.o_dc    <= 1'b0;
                tx.o_byte  <= CMD_CASET;
            end
        end
    end

endmodule
